// File: rtl/audio_frame_capture.sv
// audio_frame_capture: multi-channel sample-frame buffer in front of the FFT core.
//
// Captures DEPTH consecutive samples (CH channels x SAMPLE_W bits, channel 0 in the
// LSBs) on rising edges of new_sample. When the frame is full, it streams the frame
// out oldest-first over a valid/ready interface, tagged with out_index.
//
// Optional feature macro: AUDIO_FRAME_OVERLAP_EN
//   When defined, a completed readout goes straight back to capture. The newest
//   DEPTH-HOP samples are kept and the next frame completes after HOP new samples.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   start_write    rising edge arms or restarts capture
//   start_read     rising edge starts readout of a full frame
//   new_sample     rising edge captures in_data
//   in_data        packed input sample, CH*SAMPLE_W bits
//   out_data       packed output sample
//   out_valid      out_data and out_index are valid
//   out_ready      consumer accepts the current word
//   out_index      frame position of out_data; 0 is the oldest sample
//   write_complete one-cycle pulse when the frame fills
//   read_complete  one-cycle pulse after the last word is accepted
//   frame_ready    high while a full frame waits for readout
//   fill_level     samples captured in the current frame
//   overrun        sticky: a sample arrived while the frame was full or being read
module audio_frame_capture #(
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned CH       = 2,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned HOP      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_write,
  input  logic                   start_read,
  input  logic                   new_sample,
  input  logic [CH*SAMPLE_W-1:0] in_data,
  output logic [CH*SAMPLE_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_index,
  output logic                   write_complete,
  output logic                   read_complete,
  output logic                   frame_ready,
  output logic [ADDR_W:0]        fill_level,
  output logic                   overrun
);

  localparam int unsigned         DataW    = CH * SAMPLE_W;
  localparam logic [ADDR_W:0]     DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0]   LastIdx  = ADDR_W'(DEPTH - 1);
`ifdef AUDIO_FRAME_OVERLAP_EN
  localparam logic [ADDR_W:0]     KeepCnt  = (ADDR_W + 1)'(DEPTH - HOP);
  // HOP == DEPTH truncates to 0, which is the correct modulo-DEPTH step.
  localparam logic [ADDR_W-1:0]   HopStep  = ADDR_W'(HOP);
`endif

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 4");
  end
  if ((32'd1 << ADDR_W) != DEPTH) begin : g_bad_addr_w
    $error("ADDR_W must equal log2(DEPTH)");
  end
  if (HOP < 1 || HOP > DEPTH) begin : g_bad_hop
    $error("HOP must satisfy 1 <= HOP <= DEPTH");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StFull, StRead} state_e;

  state_e state_q, state_d;

  // Edge detectors: cur is the registered input, prev is cur one cycle later.
  logic sw_cur_q, sw_prev_q;
  logic sr_cur_q, sr_prev_q;
  logic ns_cur_q, ns_prev_q;
  logic sw_edge, sr_edge, ns_edge;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] start_q, start_d;  // memory slot holding frame index 0
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              valid_q, valid_d;
  logic              wc_q, wc_d;
  logic              rc_q, rc_d;
  logic              ovr_q, ovr_d;
  logic              mem_we;

  logic [DataW-1:0]  mem [DEPTH];

  assign sw_edge = sw_cur_q & ~sw_prev_q;
  assign sr_edge = sr_cur_q & ~sr_prev_q;
  assign ns_edge = ns_cur_q & ~ns_prev_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    start_d  = start_q;
    idx_d    = idx_q;
    fill_d   = fill_q;
    valid_d  = valid_q;
    wc_d     = 1'b0;
    rc_d     = 1'b0;
    ovr_d    = ovr_q;
    mem_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sw_edge) begin
          state_d = StWrite;
          start_d = wr_ptr_q;
          fill_d  = '0;
          ovr_d   = 1'b0;
        end
      end

      StWrite: begin
        if (sw_edge) begin
          // Restart: the new frame begins wherever the write pointer is now.
          start_d = wr_ptr_q;
          fill_d  = '0;
          ovr_d   = 1'b0;
        end else if (ns_edge) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fill_q < DepthCnt) begin
            fill_d = fill_q + 1'b1;
          end
          if (fill_q == DepthCnt - 1'b1) begin
            wc_d    = 1'b1;
            state_d = StFull;
          end
        end
      end

      StFull: begin
        if (ns_edge) begin
          ovr_d = 1'b1;
        end
        // start_read takes priority over a simultaneous start_write.
        if (sr_edge) begin
          state_d  = StRead;
          rd_ptr_d = start_q;
          idx_d    = '0;
          valid_d  = 1'b1;
        end else if (sw_edge) begin
          state_d = StWrite;
          start_d = wr_ptr_q;
          fill_d  = '0;
          ovr_d   = 1'b0;
        end
      end

      StRead: begin
        if (ns_edge) begin
          ovr_d = 1'b1;
        end
        if (valid_q && out_ready) begin
          if (idx_q == LastIdx) begin
            rc_d    = 1'b1;
            valid_d = 1'b0;
            idx_d   = '0;
`ifdef AUDIO_FRAME_OVERLAP_EN
            // Keep the newest DEPTH-HOP samples; wr_ptr already points at the
            // oldest slot, which is the first one to be overwritten.
            state_d = StWrite;
            start_d = start_q + HopStep;
            fill_d  = KeepCnt;
`else
            state_d = StIdle;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            idx_d    = idx_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      sw_cur_q  <= 1'b0;
      sw_prev_q <= 1'b0;
      sr_cur_q  <= 1'b0;
      sr_prev_q <= 1'b0;
      ns_cur_q  <= 1'b0;
      ns_prev_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      start_q   <= '0;
      idx_q     <= '0;
      fill_q    <= '0;
      valid_q   <= 1'b0;
      wc_q      <= 1'b0;
      rc_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_cur_q  <= start_write;
      sw_prev_q <= sw_cur_q;
      sr_cur_q  <= start_read;
      sr_prev_q <= sr_cur_q;
      ns_cur_q  <= new_sample;
      ns_prev_q <= ns_cur_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      start_q   <= start_d;
      idx_q     <= idx_d;
      fill_q    <= fill_d;
      valid_q   <= valid_d;
      wc_q      <= wc_d;
      rc_q      <= rc_d;
      ovr_q     <= ovr_d;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Memory is never written during readout, so the word holds under backpressure.
  assign out_data       = valid_q ? mem[rd_ptr_q] : '0;
  assign out_valid      = valid_q;
  assign out_index      = idx_q;
  assign write_complete = wc_q;
  assign read_complete  = rc_q;
  assign frame_ready    = (state_q == StFull);
  assign fill_level     = fill_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_audio_frame_capture.sv
// Self-checking bench for audio_frame_capture (DEPTH=8, CH=2, SAMPLE_W=24, HOP=4).
// The reference model keeps the current frame as a queue of samples, oldest first.
`timescale 1ns / 1ps
module tb_audio_frame_capture;

  localparam int SW    = 24;
  localparam int CHN   = 2;
  localparam int DW    = SW * CHN;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int HOP   = 4;

  localparam int MIdle  = 0;
  localparam int MWrite = 1;
  localparam int MFull  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_write, start_read, new_sample, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          out_valid, write_complete, read_complete, frame_ready, overrun;
  logic [AW-1:0] out_index;
  logic [AW:0]   fill_level;

  int n_tests = 0;
  int n_fail  = 0;
  int wc_seen = 0;
  int rc_seen = 0;

  // Reference model state.
  logic [DW-1:0] frame [$];
  int            mode    = MIdle;
  int            exp_wc  = 0;
  int            exp_rc  = 0;
  logic          exp_ovr = 1'b0;

  audio_frame_capture #(
    .SAMPLE_W (SW),
    .CH       (CHN),
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .HOP      (HOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_write    (start_write),
    .start_read     (start_read),
    .new_sample     (new_sample),
    .in_data        (in_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_index      (out_index),
    .write_complete (write_complete),
    .read_complete  (read_complete),
    .frame_ready    (frame_ready),
    .fill_level     (fill_level),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_complete) wc_seen++;
    if (read_complete)  rc_seen++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_fill"},  64'(fill_level), 64'(frame.size()));
    check_eq({tag, "_ready"}, 64'(frame_ready), 64'(mode == MFull));
    check_eq({tag, "_ovr"},   64'(overrun), 64'(exp_ovr));
    check_eq({tag, "_wc"},    64'(wc_seen), 64'(exp_wc));
    check_eq({tag, "_rc"},    64'(rc_seen), 64'(exp_rc));
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic sw_op();
    start_write = 1'b1;
    tick(); tick();
    start_write = 1'b0;
    tick(); tick();
    frame.delete();
    mode    = MWrite;
    exp_ovr = 1'b0;
    check_status("sw");
  endtask

  task automatic sr_ignored_op();
    start_read = 1'b1;
    tick(); tick();
    start_read = 1'b0;
    tick(); tick();
    check_status("sr_ign");
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    in_data    = d;
    new_sample = 1'b1;
    tick(); tick();
    new_sample = 1'b0;
    tick(); tick();
    if (mode == MWrite) begin
      frame.push_back(d);
      if (frame.size() == DEPTH) begin
        mode = MFull;
        exp_wc++;
      end
    end else if (mode == MFull) begin
      exp_ovr = 1'b1;
    end
    check_status("smp");
  endtask

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  // rmode: 0 always ready, 1 stall 5 cycles at index 3, 2 random ready.
  // abort_at >= 0 returns with that index presented and nothing accepted after it.
  task automatic do_read(input int rmode, input int abort_at, input bit with_sw);
    logic [DW-1:0] exp [$];
    int acc, cyc, hold;
    exp  = frame;
    acc  = 0;
    hold = 0;
    start_read  = 1'b1;
    start_write = with_sw;
    out_ready   = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      tick();
      cyc++;
      start_read  = 1'b0;
      start_write = 1'b0;
    end
    start_read  = 1'b0;
    start_write = 1'b0;
    check_eq("rd_start_valid", 64'(out_valid), 64'd1);
    if (!out_valid) return;
    cyc = 0;
    while (acc < DEPTH && cyc < 40 * DEPTH) begin
      if (abort_at >= 0 && acc == abort_at) begin
        out_ready = 1'b0;
        check_eq("rd_abort_idx", 64'(out_index), 64'(acc));
        return;
      end
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (acc == 3 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      check_eq("rd_valid", 64'(out_valid), 64'd1);
      check_eq("rd_index", 64'(out_index), 64'(acc));
      check_eq("rd_data",  64'(out_data), 64'(exp[acc]));
      if (out_ready) acc++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check_eq("rd_count",     64'(acc), 64'(DEPTH));
    check_eq("rd_end_valid", 64'(out_valid), 64'd0);
    check_eq("rd_cmp_pulse", 64'(read_complete), 64'd1);
    tick();
    check_eq("rd_cmp_once",  64'(read_complete), 64'd0);
    exp_rc++;
`ifdef AUDIO_FRAME_OVERLAP_EN
    repeat (HOP) void'(frame.pop_front());
    mode = MWrite;
`else
    mode = MIdle;
`endif
    check_status("rd");
  endtask

  task automatic fill_frame();
    if (mode == MIdle) sw_op();
    while (mode == MWrite) send_sample(rand_word());
  endtask

  initial begin
    rst = 1'b0;
    start_write = 1'b0;
    start_read  = 1'b0;
    new_sample  = 1'b0;
    out_ready   = 1'b0;
    in_data     = '0;
    tick(); tick(); tick();
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data",  64'(out_data), 64'd0);
    check_eq("rst_index", 64'(out_index), 64'd0);
    check_eq("rst_wc",    64'(write_complete), 64'd0);
    check_eq("rst_rc",    64'(read_complete), 64'd0);
    check_eq("rst_ready", 64'(frame_ready), 64'd0);
    check_eq("rst_fill",  64'(fill_level), 64'd0);
    check_eq("rst_ovr",   64'(overrun), 64'd0);
    rst = 1'b1;
    tick();

    // Basic frame: ch1 = k, ch0 = 10 + k.
    sw_op();
    for (int k = 0; k < DEPTH; k++) send_sample({24'(k), 24'(10 + k)});
    do_read(0, -1, 1'b0);

    // Next frame (overlap: four new samples k = 8..11), read with a stall at index 3.
    if (mode == MIdle) sw_op();
    begin
      int k = 8;
      while (mode == MWrite) begin
        send_sample({24'(k), 24'(10 + k)});
        k++;
      end
    end
    do_read(1, -1, 1'b0);

    // Overrun while full, frame unaffected, start_write clears the flag.
    fill_frame();
    for (int i = 0; i < 3; i++) send_sample(rand_word());
    do_read(2, -1, 1'b0);
    sw_op();

    // Restart after five samples, then a full eight are required.
    for (int i = 0; i < 5; i++) send_sample(rand_word());
    sw_op();
    for (int i = 0; i < DEPTH; i++) send_sample(rand_word());

    // start_read and start_write edges together while full: read wins.
    do_read(0, -1, 1'b1);

    // Random operation mix.
    for (int step = 0; step < 80; step++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        send_sample(rand_word());
      end else if (op == 6) begin
        sw_op();
      end else if (op == 7 || op == 9) begin
        if (mode == MFull) do_read($urandom_range(0, 2), -1, 1'b0);
        else sr_ignored_op();
      end else begin
        if (mode == MFull) do_read($urandom_range(0, 2), -1, 1'b1);
        else sw_op();
      end
    end

    // Asynchronous reset in the middle of a readout.
    fill_frame();
    do_read(0, 4, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_ready", 64'(frame_ready), 64'd0);
    check_eq("arst_fill",  64'(fill_level), 64'd0);
    check_eq("arst_ovr",   64'(overrun), 64'd0);
    check_eq("arst_index", 64'(out_index), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    frame.delete();
    mode    = MIdle;
    exp_ovr = 1'b0;
    check_status("post_rst");

    // A fresh frame still works after the reset.
    fill_frame();
    do_read(2, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
